// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile
//   AXI4-Lite slave exposing NUM_REGS registers of DATA_WIDTH bits each.
//   The write address and write data channels are captured independently
//   into holding registers; a write commits in the first cycle both are
//   held. Reads return the registered value one cycle after the AR
//   handshake. At most one write and one read response are outstanding.
//
// Ports
//   clk                 : clock, rising edge
//   rst_n               : synchronous active-low reset
//   aw_addr/valid/ready : write address channel
//   w_data/strb/valid/ready : write data channel
//   b_resp/valid/ready  : write response channel
//   ar_addr/valid/ready : read address channel
//   r_data/resp/valid/ready : read data channel
//   reg_q               : all register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse            : one-cycle strobe per register on a committed write
module axi_lite_regfile #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          aw_addr,
  input  logic                           aw_valid,
  output logic                           aw_ready,
  input  logic [DATA_WIDTH-1:0]          w_data,
  input  logic [DATA_WIDTH/8-1:0]        w_strb,
  input  logic                           w_valid,
  output logic                           w_ready,
  output logic [1:0]                     b_resp,
  output logic                           b_valid,
  input  logic                           b_ready,
  input  logic [ADDR_WIDTH-1:0]          ar_addr,
  input  logic                           ar_valid,
  output logic                           ar_ready,
  output logic [DATA_WIDTH-1:0]          r_data,
  output logic [1:0]                     r_resp,
  output logic                           r_valid,
  input  logic                           r_ready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TOP    = LSB + IDX_W;
  localparam logic [IDX_W:0] NUM_REGS_V = (IDX_W + 1)'(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[LSB +: IDX_W];
  endfunction

  // In range: nothing set above the index field and index below NUM_REGS.
  // The byte-offset bits below LSB are don't-care.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return ((a >> TOP) == '0) && ({1'b0, a[LSB +: IDX_W]} < NUM_REGS_V);
  endfunction

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic              aw_held;
  logic [IDX_W-1:0]  aw_idx_q;
  logic              aw_ok_q;
  logic              w_held;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic              commit;

  // Readies come only from internal state; rst_n forces them low while
  // reset is asserted.
  assign aw_ready = rst_n & ~aw_held & ~b_valid;
  assign w_ready  = rst_n & ~w_held & ~b_valid;
  assign ar_ready = rst_n & ~r_valid;
  assign commit   = aw_held & w_held;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_held  <= 1'b0;
      aw_idx_q <= '0;
      aw_ok_q  <= 1'b0;
      w_held   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
      b_valid  <= 1'b0;
      b_resp   <= RESP_OKAY;
      wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      wr_pulse <= '0;

      if (aw_valid && aw_ready) begin
        aw_held  <= 1'b1;
        aw_idx_q <= addr_idx(aw_addr);
        aw_ok_q  <= addr_ok(aw_addr);
      end

      if (w_valid && w_ready) begin
        w_held   <= 1'b1;
        w_data_q <= w_data;
        w_strb_q <= w_strb;
      end

      // Holding registers cannot refill while b_valid is up, so a commit
      // never overlaps an outstanding response.
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        b_valid <= 1'b1;
        b_resp  <= aw_ok_q ? RESP_OKAY : RESP_SLVERR;
        if (aw_ok_q) begin
          wr_pulse[aw_idx_q] <= 1'b1;
          for (int k = 0; k < STRB_W; k++) begin
            if (w_strb_q[k]) begin
              regs[aw_idx_q][k*8 +: 8] <= w_data_q[k*8 +: 8];
            end
          end
        end
      end else if (b_valid && b_ready) begin
        b_valid <= 1'b0;
      end
    end
  end

  // Read path runs independently of the write path. A read sampled on the
  // same edge as a commit sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_resp  <= RESP_OKAY;
    end else if (ar_valid && ar_ready) begin
      r_valid <= 1'b1;
      if (addr_ok(ar_addr)) begin
        r_data <= regs[addr_idx(ar_addr)];
        r_resp <= RESP_OKAY;
      end else begin
        r_data <= '0;
        r_resp <= RESP_SLVERR;
      end
    end else if (r_valid && r_ready) begin
      r_valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile with default parameters
// (32-bit address/data, 16 registers).
module tb_axi_lite_regfile;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  aw_addr;
  logic         aw_valid;
  logic         aw_ready;
  logic [31:0]  w_data;
  logic [3:0]   w_strb;
  logic         w_valid;
  logic         w_ready;
  logic [1:0]   b_resp;
  logic         b_valid;
  logic         b_ready;
  logic [31:0]  ar_addr;
  logic         ar_valid;
  logic         ar_ready;
  logic [31:0]  r_data;
  logic [1:0]   r_resp;
  logic         r_valid;
  logic         r_ready;
  logic [511:0] reg_q;
  logic [15:0]  wr_pulse;

  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] model [16];

  axi_lite_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .reg_q(reg_q), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s_reg%0d", tag, i), reg_q[i*32 +: 32], model[i]);
    end
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    return a[31:6] == 26'd0;
  endfunction

  // Expected effect of one committed write on the register model.
  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_rng(a)) begin
      for (int k = 0; k < 4; k++) begin
        if (s[k]) model[a[5:2]][k*8 +: 8] = d[k*8 +: 8];
      end
    end
  endtask

  // AW and W in the same cycle; b_valid expected on the next edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [15:0] exp_pulse;
    exp_pulse = in_rng(a) ? (16'd1 << a[5:2]) : 16'd0;
    aw_addr = a; aw_valid = 1'b1;
    w_data = d; w_strb = s; w_valid = 1'b1;
    chk("wr_aw_ready", aw_ready, 1);
    chk("wr_w_ready", w_ready, 1);
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    chk("wr_no_early_b", b_valid, 0);
    tick();
    model_write(a, d, s);
    chk("wr_b_valid", b_valid, 1);
    chk("wr_b_resp", b_resp, in_rng(a) ? 2'b00 : 2'b10);
    chk("wr_pulse", wr_pulse, exp_pulse);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    chk("wr_b_clear", b_valid, 0);
    chk("wr_pulse_clear", wr_pulse, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d,
                         input logic [1:0] exp_r, input int hold);
    ar_addr = a; ar_valid = 1'b1;
    chk("rd_ar_ready", ar_ready, 1);
    tick();
    ar_valid = 1'b0;
    for (int i = 0; i <= hold; i++) begin
      chk("rd_r_valid", r_valid, 1);
      chk("rd_r_data", r_data, exp_d);
      chk("rd_r_resp", r_resp, exp_r);
      chk("rd_ar_busy", ar_ready, 0);
      if (i < hold) tick();
    end
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    chk("rd_r_clear", r_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    aw_addr = '0; aw_valid = 1'b0;
    w_data = '0; w_strb = '0; w_valid = 1'b0;
    b_ready = 1'b0;
    ar_addr = '0; ar_valid = 1'b0;
    r_ready = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_reg_q", reg_q, 0);
    chk("rst_wr_pulse", wr_pulse, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_aw_ready", aw_ready, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_ar_ready", ar_ready, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_aw_ready", aw_ready, 1);
    chk("post_rst_w_ready", w_ready, 1);
    chk("post_rst_ar_ready", ar_ready, 1);

    // W three cycles ahead of AW
    w_data = 32'hDEADBEEF; w_strb = 4'hF; w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    chk("wfirst_w_ready", w_ready, 0);
    chk("wfirst_aw_ready", aw_ready, 1);
    tick();
    tick();
    chk("wfirst_no_b", b_valid, 0);
    aw_addr = 32'h08; aw_valid = 1'b1;
    tick();
    aw_valid = 1'b0;
    chk("wfirst_no_b2", b_valid, 0);
    chk("wfirst_no_pulse", wr_pulse, 0);
    tick();
    model[2] = 32'hDEADBEEF;
    chk("wfirst_reg2", reg_q[2*32 +: 32], 32'hDEADBEEF);
    chk("wfirst_pulse", wr_pulse, 16'h0004);
    chk("wfirst_b_valid", b_valid, 1);
    chk("wfirst_b_resp", b_resp, 2'b00);
    chk("wfirst_aw_ready_busy", aw_ready, 0);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    chk("wfirst_b_clear", b_valid, 0);
    chk("wfirst_pulse_clear", wr_pulse, 0);

    // Byte strobes
    do_write(32'h04, 32'h11223344, 4'hF);
    do_write(32'h04, 32'hAABBCCDD, 4'b0101);
    chk("strb_reg1", reg_q[1*32 +: 32], 32'h11BB33DD);
    do_write(32'h10, 32'hFFFFFFFF, 4'h0);
    chk("strb0_reg4", reg_q[4*32 +: 32], 32'h0);
    // Byte offset bits are ignored
    do_write(32'h1F, 32'hCAFE0007, 4'hF);
    chk_regs("after_strb");

    // Out of range
    do_write(32'h40, 32'h12345678, 4'hF);
    do_write(32'h8000_0000, 32'h87654321, 4'hF);
    chk_regs("after_oor");
    do_read(32'h40, 32'h0, 2'b10, 0);
    do_read(32'h04, 32'h11BB33DD, 2'b00, 3);
    do_read(32'h1E, 32'hCAFE0007, 2'b00, 0);

    // Back-pressure on B
    aw_addr = 32'h14; aw_valid = 1'b1;
    w_data = 32'h55; w_strb = 4'hF; w_valid = 1'b1;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    tick();
    model[5] = 32'h55;
    for (int i = 0; i < 5; i++) begin
      chk("bp_b_valid", b_valid, 1);
      chk("bp_b_resp", b_resp, 2'b00);
      chk("bp_aw_ready", aw_ready, 0);
      chk("bp_w_ready", w_ready, 0);
      tick();
    end
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    aw_addr = 32'h18; aw_valid = 1'b1;
    chk("bp_aw_ready_again", aw_ready, 1);
    tick();
    aw_valid = 1'b0;
    chk("bp_aw_held", aw_ready, 0);
    w_data = 32'h66; w_strb = 4'hF; w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    tick();
    model[6] = 32'h66;
    chk("bp2_b_valid", b_valid, 1);
    chk("bp2_pulse", wr_pulse, 16'h0040);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    chk_regs("after_bp");

    // Read and commit to the same register on the same edge
    do_write(32'h0C, 32'h5, 4'hF);
    aw_addr = 32'h0C; aw_valid = 1'b1;
    w_data = 32'h9; w_strb = 4'hF; w_valid = 1'b1;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    ar_addr = 32'h0C; ar_valid = 1'b1;
    chk("race_ar_ready", ar_ready, 1);
    tick();
    ar_valid = 1'b0;
    model[3] = 32'h9;
    chk("race_r_valid", r_valid, 1);
    chk("race_r_data_old", r_data, 32'h5);
    chk("race_b_valid", b_valid, 1);
    chk("race_reg3_new", reg_q[3*32 +: 32], 32'h9);
    r_ready = 1'b1; b_ready = 1'b1;
    tick();
    r_ready = 1'b0; b_ready = 1'b0;
    do_read(32'h0C, 32'h9, 2'b00, 0);

    // Reset with W held and R pending
    w_data = 32'h77; w_strb = 4'hF; w_valid = 1'b1;
    ar_addr = 32'h08; ar_valid = 1'b1;
    tick();
    w_valid = 1'b0; ar_valid = 1'b0;
    chk("mid_r_valid", r_valid, 1);
    chk("mid_r_data", r_data, 32'hDEADBEEF);
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) model[i] = '0;
    chk("mid_rst_reg_q", reg_q, 0);
    chk("mid_rst_pulse", wr_pulse, 0);
    chk("mid_rst_b_valid", b_valid, 0);
    chk("mid_rst_b_resp", b_resp, 0);
    chk("mid_rst_r_valid", r_valid, 0);
    chk("mid_rst_r_data", r_data, 0);
    chk("mid_rst_r_resp", r_resp, 0);
    chk("mid_rst_aw_ready", aw_ready, 0);
    chk("mid_rst_w_ready", w_ready, 0);
    chk("mid_rst_ar_ready", ar_ready, 0);
    rst_n = 1'b1;
    tick();
    aw_addr = 32'h18; aw_valid = 1'b1;
    tick();
    aw_valid = 1'b0;
    tick();
    tick();
    chk("aw_only_no_b", b_valid, 0);
    chk("aw_only_no_pulse", wr_pulse, 0);
    chk("aw_only_w_ready", w_ready, 1);
    chk_regs("aw_only");
    w_data = 32'h77; w_strb = 4'hF; w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
    tick();
    model[6] = 32'h77;
    chk("late_w_b_valid", b_valid, 1);
    chk("late_w_pulse", wr_pulse, 16'h0040);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    chk_regs("final");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_regfile.md
AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the byte-address width of aw_addr and ar_addr.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the data width; legal values are 32 and 64.
REQ-003 Parameter NUM_REGS, default 16, SHALL set the register count; legal range is 1..256.
REQ-004 Derived constant STRB_W = DATA_WIDTH/8, LSB = log2(STRB_W) and IDX_W = max(1, clog2(NUM_REGS)).
REQ-005 Port clk, input, 1: the single clock; all logic is synchronous to its rising edge.
REQ-006 Port rst_n, input, 1: reset; it is synchronous and active-low.
REQ-007 Ports aw_addr (in, ADDR_WIDTH), aw_valid (in, 1), aw_ready (out, 1): write address channel.
REQ-008 Ports w_data (in, DATA_WIDTH), w_strb (in, STRB_W), w_valid (in, 1), w_ready (out, 1): write data channel.
REQ-009 Ports b_resp (out, 2), b_valid (out, 1), b_ready (in, 1): write response channel.
REQ-010 Ports ar_addr (in, ADDR_WIDTH), ar_valid (in, 1), ar_ready (out, 1): read address channel.
REQ-011 Ports r_data (out, DATA_WIDTH), r_resp (out, 2), r_valid (out, 1), r_ready (in, 1): read data channel.
REQ-012 Port reg_q, out, NUM_REGS*DATA_WIDTH: register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 Port wr_pulse, out, NUM_REGS: one-cycle strobe per register on a committed write.

Function
REQ-014 Address decode: index = addr[LSB +: IDX_W]; addr[LSB-1:0] is ignored.
REQ-015 An access SHALL be in range when all addr bits above LSB+IDX_W-1 are zero and index < NUM_REGS.
REQ-016 Responses: OKAY = 2'b00 for in-range accesses; SLVERR = 2'b10 for out-of-range accesses.
REQ-017 The AW and W channels SHALL be captured independently into separate holding registers, in either order or in the same cycle.
REQ-018 aw_ready = no AW held and b_valid low.
REQ-019 w_ready = no W held and b_valid low.
REQ-020 Commit SHALL occur in the first cycle in which both AW and W are held.
REQ-021 On commit of an in-range write, each byte k of the register is updated to w_data byte k where w_strb[k]=1.
REQ-022 On commit, wr_pulse[index] SHALL be high for exactly that one cycle, including when w_strb = 0.
REQ-023 On commit, both holding registers are cleared and b_valid/b_resp are set; total latency from the later of the two handshakes to b_valid is 1 cycle.
REQ-024 An out-of-range write SHALL modify no register, raise no wr_pulse, and return SLVERR.
REQ-025 b_valid and b_resp SHALL be held stable until b_valid && b_ready; b_valid clears in the following cycle.
REQ-026 The block SHALL hold at most one write outstanding.
REQ-027 ar_ready = !r_valid.
REQ-028 On ar handshake, in the next cycle: r_valid=1, r_data = register value (0 if out of range), r_resp = OKAY/SLVERR.
REQ-029 r_data and r_resp SHALL remain stable until r_valid && r_ready; r_valid then clears, giving a maximum read throughput of one read per 2 cycles.
REQ-030 If a read is accepted in the same cycle a write commits to the same register, r_data SHALL return the pre-write value.
REQ-031 Read and write paths SHALL operate concurrently without mutual stalls.
REQ-032 A write SHALL appear on reg_q one cycle after commit.
REQ-033 The handshake-gating condition for b_valid, r_valid and the holding registers SHALL depend only on internal state and never combinationally on valid inputs.

Reset
REQ-034 On a clk edge with rst_n=0: all registers, reg_q, wr_pulse, b_valid, r_valid, r_data, b_resp and r_resp SHALL be 0, and both holding registers empty.
REQ-035 During reset, aw_ready, w_ready and ar_ready SHALL be 0; they reflect REQ-018, REQ-019 and REQ-027 from the first cycle after rst_n=1.
REQ-036 A reset mid-transaction SHALL discard held AW/W and pending B/R with no register update.

Verification
REQ-037 W (w_data=32'hDEADBEEF, w_strb=4'hF) precedes AW (addr 0x08) by 3 cycles -> one cycle later reg 2 = 32'hDEADBEEF, wr_pulse[2]=1, b_valid=1 with b_resp=OKAY.
REQ-038 Reg 1 = 32'h11223344; write 32'hAABBCCDD with w_strb=4'b0101 -> reg 1 = 32'h11BB33DD.
REQ-039 NUM_REGS=16: write to 0x40, then read 0x40 -> no register change, b_resp=SLVERR, r_data=0, r_resp=SLVERR.
REQ-040 b_ready held low for 5 cycles -> b_valid held with stable b_resp, aw_ready/w_ready=0 throughout; a second AW is accepted 1 cycle after b handshake.
REQ-041 Reg 3 = 32'h5; same-cycle read of 0x0C and commit of 32'h9 to 0x0C -> r_data=32'h5; a subsequent read returns 32'h9.
REQ-042 rst_n=0 asserted with W held and r_valid pending -> next cycle all outputs 0; a later AW alone causes no commit.
